// File: rtl/recompute_output_merger_os.sv
// Collects the raw array matrix and per-RU recomputed words, patches faulty PEs, and emits the corrected matrix.
// Latency: NUM_RU cycles of merge after the last capture; out_valid/out_matrix hold until out_ready.
module recompute_output_merger_os #(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int WORD_SIZE = 16,
  parameter int NUM_RU    = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 array_valid,
  input  logic [ROWS*COLS*WORD_SIZE-1:0]       array_result,
  input  logic [NUM_RU-1:0]                    ru_en,
  input  logic [NUM_RU-1:0]                    ru_output_valid,
  input  logic [NUM_RU*WORD_SIZE-1:0]          ru_result,
  input  logic [NUM_RU*$clog2(ROWS)-1:0]       ru_row_mapping,
  input  logic [NUM_RU*$clog2(COLS)-1:0]       ru_col_mapping,
  input  logic                                 out_ready,
  output logic                                 out_valid,
  output logic [ROWS*COLS*WORD_SIZE-1:0]       out_matrix,
  output logic                                 busy,
  output logic                                 merge_error,
  output logic [$clog2(NUM_RU+1)-1:0]          patched_count
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int IW = (NUM_RU > 1) ? $clog2(NUM_RU) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int PW = $clog2(NUM_RU+1);
  localparam int MW = ROWS*COLS*WORD_SIZE;

  typedef enum logic [1:0] {IDLE, COLLECT, MERGE, OUTPUT} state_t;

  state_t                      state;
  logic [MW-1:0]               work;
  logic [MW-1:0]               work_next;
  logic [NUM_RU*WORD_SIZE-1:0] ru_buf;
  logic [NUM_RU-1:0]           got;
  logic [NUM_RU-1:0]           cap_en;
  logic [NUM_RU-1:0]           got_next;
  logic                        arr_got;
  logic                        all_done;
  logic                        do_patch;
  logic [TW-1:0]               timer;
  logic [IW-1:0]               merge_idx;
  logic [RW-1:0]               row_sel;
  logic [CW-1:0]               col_sel;

  function automatic logic in_range(input int r, input int c);
    return (r < ROWS) && (c < COLS);
  endfunction

  assign busy = (state != IDLE);

  // RU results may arrive before the array matrix, so IDLE captures as well.
  always_comb begin
    cap_en = '0;
    if (state == IDLE || state == COLLECT)
      cap_en = ru_output_valid & ru_en & ~got;
  end

  assign got_next = got | cap_en;
  assign all_done = arr_got && (&(got_next | ~ru_en));

  always_comb begin
    int pe;
    work_next = work;
    do_patch  = 1'b0;
    row_sel   = ru_row_mapping[int'(merge_idx)*RW +: RW];
    col_sel   = ru_col_mapping[int'(merge_idx)*CW +: CW];
    pe        = int'(row_sel)*COLS + int'(col_sel);
    if (ru_en[merge_idx] && got[merge_idx] && in_range(int'(row_sel), int'(col_sel))) begin
      do_patch = 1'b1;
      work_next[pe*WORD_SIZE +: WORD_SIZE] = ru_buf[int'(merge_idx)*WORD_SIZE +: WORD_SIZE];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      work          <= '0;
      ru_buf        <= '0;
      got           <= '0;
      arr_got       <= 1'b0;
      timer         <= '0;
      merge_idx     <= '0;
      out_valid     <= 1'b0;
      out_matrix    <= '0;
      merge_error   <= 1'b0;
      patched_count <= '0;
    end else begin
      for (int i = 0; i < NUM_RU; i++)
        if (cap_en[i]) ru_buf[i*WORD_SIZE +: WORD_SIZE] <= ru_result[i*WORD_SIZE +: WORD_SIZE];

      case (state)
        IDLE: begin
          got <= got_next;
          if (array_valid) begin
            work          <= array_result;
            arr_got       <= 1'b1;
            timer         <= '0;
            patched_count <= '0;
            merge_error   <= 1'b0;
            state         <= COLLECT;
          end
        end
        COLLECT: begin
          got <= got_next;
          // Completion takes priority over a timeout landing in the same cycle.
          if (all_done) begin
            merge_idx <= '0;
            state     <= MERGE;
          end else if (timer == TW'(TIMEOUT-1)) begin
            merge_error <= 1'b1;
            merge_idx   <= '0;
            state       <= MERGE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        MERGE: begin
          work <= work_next;
          if (do_patch) patched_count <= patched_count + PW'(1);
          if (merge_idx == IW'(NUM_RU-1)) begin
            out_matrix <= work_next;
            out_valid  <= 1'b1;
            state      <= OUTPUT;
          end else begin
            merge_idx <= merge_idx + IW'(1);
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            got       <= '0;
            arr_got   <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
